// File: rtl/tri_cmd_pkg.sv
// Shared types and constants for the triangle command master.
package tri_cmd_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, GAP} state_t;

    localparam int WORDS_PER_TRI = 7;
    localparam int WORD_W        = 16;
    localparam int TRI_W         = 112;

    localparam logic [2:0] IDX_V1X   = 3'd0;
    localparam logic [2:0] IDX_V1Y   = 3'd1;
    localparam logic [2:0] IDX_V2X   = 3'd2;
    localparam logic [2:0] IDX_V2Y   = 3'd3;
    localparam logic [2:0] IDX_V3X   = 3'd4;
    localparam logic [2:0] IDX_V3Y   = 3'd5;
    localparam logic [2:0] IDX_COLOR = 3'd6;

    // Word k of a packed command lives at bits [16k+15:16k].
    function automatic logic [WORD_W-1:0] tri_word(input logic [TRI_W-1:0] t,
                                                   input logic [2:0]       idx);
        case (idx)
            IDX_V1X: return t[15:0];
            IDX_V1Y: return t[31:16];
            IDX_V2X: return t[47:32];
            IDX_V2Y: return t[63:48];
            IDX_V3X: return t[79:64];
            IDX_V3Y: return t[95:80];
            default: return t[111:96];
        endcase
    endfunction

endpackage

// File: rtl/tri_cmd_master_if.sv
// Command stream plus Avalon-MM write bus between generator, master and peripheral.
interface tri_cmd_master_if;
    import tri_cmd_pkg::*;

    logic [TRI_W-1:0]  tri_data;
    logic              tri_valid;
    logic              tri_ready;
    logic [7:0]        address;
    logic [WORD_W-1:0] writedata;
    logic              write;
    logic              chipselect;
    logic              waitrequest;

    modport master (
        input  tri_data, tri_valid, waitrequest,
        output tri_ready, address, writedata, write, chipselect
    );

    modport slave (
        output tri_data, tri_valid, waitrequest,
        input  tri_ready, address, writedata, write, chipselect
    );

endinterface

// File: rtl/tri_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module tri_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             push_ok, pop_ok;

    // Extra MSB on each pointer distinguishes full from empty after wrap.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tri_cmd_master.sv
// Buffers triangle commands and serialises each into seven Avalon word writes.
// Optional TRI_CMD_STATS_EN adds tri_count / stall_count statistics outputs.
module tri_cmd_master
    import tri_cmd_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] BASE_ADDR  = 8'd0,
    parameter int         GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    tri_cmd_master_if.master  bus,
`ifdef TRI_CMD_STATS_EN
    output logic [15:0]       tri_count,
    output logic [31:0]       stall_count,
`endif
    output logic              busy
);

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [TRI_W-1:0]  fifo_dout;

    state_t            state, state_nxt;
    logic [2:0]        k, k_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;
    logic [TRI_W-1:0]  hold, hold_nxt;
    logic [7:0]        addr_q, addr_nxt;
    logic [WORD_W-1:0] wdata_q, wdata_nxt;
    logic              write_q, write_nxt;
    logic              accept;

    assign bus.tri_ready  = !fifo_full;
    assign bus.address    = addr_q;
    assign bus.writedata  = wdata_q;
    assign bus.write      = write_q;
    assign bus.chipselect = write_q;
    assign busy           = !fifo_empty || (state != IDLE);
    // write_q is only ever high in WRITE, so stray waitrequest elsewhere is ignored.
    assign accept         = write_q && !bus.waitrequest;

    tri_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(TRI_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.tri_valid),
        .pop   (fifo_pop),
        .din   (bus.tri_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        gap_nxt   = gap_cnt;
        hold_nxt  = hold;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        write_nxt = write_q;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    hold_nxt  = fifo_dout;
                    k_nxt     = IDX_V1X;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                addr_nxt  = BASE_ADDR;
                wdata_nxt = tri_word(hold, IDX_V1X);
                write_nxt = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                if (accept) begin
                    if (k == IDX_COLOR) begin
                        write_nxt = 1'b0;
                        gap_nxt   = GAP_LAST;
                        state_nxt = GAP;
                    end else begin
                        k_nxt     = k + 3'd1;
                        addr_nxt  = addr_q + 8'd1;
                        wdata_nxt = tri_word(hold, k + 3'd1);
                    end
                end
            end
            GAP: begin
                // Idle bus lets the peripheral's start/done FSM step.
                if (gap_cnt == '0) state_nxt = IDLE;
                else               gap_nxt   = gap_cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            gap_cnt <= '0;
            hold    <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            gap_cnt <= gap_nxt;
            hold    <= hold_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            write_q <= write_nxt;
        end
    end

`ifdef TRI_CMD_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tri_count   <= '0;
            stall_count <= '0;
        end else begin
            if (accept && k == IDX_COLOR)  tri_count   <= tri_count + 16'd1;
            if (write_q && bus.waitrequest) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tri_cmd_master.sv
// Randomised scoreboard bench for tri_cmd_master (BASE_ADDR=FC exercises address wrap).
module tb_tri_cmd_master;

    localparam int         DEPTH   = 4;
    localparam logic [7:0] TB_BASE = 8'hFC;
    localparam int         GAP     = 2;

    logic clk = 1'b0;
    logic reset;
    logic busy;
`ifdef TRI_CMD_STATS_EN
    logic [15:0] tri_count;
    logic [31:0] stall_count;
`endif

    tri_cmd_master_if bus_if ();

    tri_cmd_master #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(TB_BASE), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
`ifdef TRI_CMD_STATS_EN
        .tri_count   (tri_count),
        .stall_count (stall_count),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_mode = 0;
    int stall_left = 0;

    logic [23:0] exp_q[$];
    int          start_q[$];
    int          last6 = -1000;
    int          word_idx = 0;
    int          tri_model = 0;
    int          stall_model = 0;
    logic        prev_write = 1'b0;
    logic        held = 1'b0;
    logic [7:0]  h_addr;
    logic [15:0] h_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Bus slave: waitrequest pattern chosen by the current scenario.
    always @(posedge clk) begin
        #1;
        case (wr_mode)
            0: bus_if.waitrequest = 1'b0;
            1: bus_if.waitrequest = ($urandom_range(0, 3) == 0);
            2: bus_if.waitrequest = 1'b1;
            default: begin
                if (bus_if.write && bus_if.address == 8'(TB_BASE + 8'd3) && stall_left > 0) begin
                    bus_if.waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    bus_if.waitrequest = 1'b0;
                end
            end
        endcase
    end

    // Monitor + scoreboard: inputs change only at posedge+1, so negedge values decide the next edge.
    always @(negedge clk) begin
        int se;
        logic [23:0] e;
        if (reset) begin
            exp_q.delete();
            start_q.delete();
            last6 = -1000;
            word_idx = 0;
            tri_model = 0;
            stall_model = 0;
            prev_write = 1'b0;
            held = 1'b0;
        end else begin
            chk("cs_eq_write", 32'(bus_if.chipselect), 32'(bus_if.write));
            if (held) begin
                chk("hold_write", 32'(bus_if.write), 32'd1);
                chk("hold_addr", 32'(bus_if.address), 32'(h_addr));
                chk("hold_data", 32'(bus_if.writedata), 32'(h_data));
            end
            if (bus_if.write && !prev_write) begin
                if (start_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL start: write at cycle %0d with no command queued", cyc);
                end else begin
                    se = start_q.pop_front() + 2;
                    if (last6 + GAP + 2 > se) se = last6 + GAP + 2;
                    chk("start_cycle", 32'(cyc), 32'(se));
                end
            end
            held   = bus_if.write && bus_if.waitrequest;
            h_addr = bus_if.address;
            h_data = bus_if.writedata;
            if (bus_if.write && bus_if.waitrequest) stall_model++;
            if (bus_if.write && !bus_if.waitrequest) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_write: addr %0h data %0h unexpected", bus_if.address, bus_if.writedata);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr", 32'(bus_if.address), 32'(e[23:16]));
                    chk("data", 32'(bus_if.writedata), 32'(e[15:0]));
                end
                word_idx++;
                if (word_idx == 7) begin
                    word_idx = 0;
                    last6 = cyc + 1;
                    tri_model++;
                end
            end
            prev_write = bus_if.write;
            if (bus_if.tri_valid && bus_if.tri_ready) begin
                logic [111:0] d;
                d = bus_if.tri_data;
                for (int k = 0; k < 7; k++)
                    exp_q.push_back({8'(TB_BASE + 8'(k)), d[16*k +: 16]});
                start_q.push_back(cyc + 1);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_tri(input logic [111:0] d);
        bus_if.tri_data  = d;
        bus_if.tri_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bus_if.tri_ready) begin
                @(posedge clk); #1;
                bus_if.tri_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus_if.tri_valid = 1'b0;
        total++; bad++;
        $display("FAIL push_timeout: tri_ready stayed 0");
    endtask

    task automatic drain();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                @(posedge clk); #1;
                return;
            end
        end
        total++; bad++;
        $display("FAIL drain_timeout: %0d words outstanding busy=%0d", exp_q.size(), busy);
        @(posedge clk); #1;
    endtask

    function automatic logic [111:0] rnd_tri();
        logic [111:0] t;
        for (int k = 0; k < 7; k++) t[16*k +: 16] = 16'($urandom);
        return t;
    endfunction

    initial begin
        logic [111:0] t1;
        int s0;
        reset = 1'b1;
        bus_if.tri_valid = 1'b0;
        bus_if.tri_data  = '0;
        bus_if.waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_write", 32'(bus_if.write), 32'd0);
        chk("rst_cs", 32'(bus_if.chipselect), 32'd0);
        chk("rst_addr", 32'(bus_if.address), 32'(TB_BASE));
        chk("rst_wdata", 32'(bus_if.writedata), 32'd0);
        chk("rst_ready", 32'(bus_if.tri_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Single triangle, no stalls; busy timing around the gap.
        t1 = {16'hF800, 16'h238F, 16'h06E9, 16'h0F9C, 16'h19CE, 16'h0904, 16'h0904};
        push_tri(t1);
        repeat (11) @(negedge clk);
        chk("busy_in_gap", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        drain();

        // Three-cycle stall on word 3.
        s0 = stall_model;
        wr_mode = 3; stall_left = 3;
        push_tri(t1);
        drain();
        chk("stall_cycles", 32'(stall_model - s0), 32'd3);
        wr_mode = 0;

        // Five back-to-back pushes against a permanently stalled bus.
        wr_mode = 2;
        for (int i = 0; i < 5; i++) push_tri(rnd_tri());
        @(negedge clk);
        chk("full_ready", 32'(bus_if.tri_ready), 32'd0);
        @(posedge clk); #1;
        bus_if.tri_data = rnd_tri();
        bus_if.tri_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_if.tri_valid = 1'b0;
        wr_mode = 0;
        drain();

        // Reset while word 4 is on the bus.
        push_tri(rnd_tri());
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (word_idx == 4) break;
        end
        chk("k4_write", 32'(bus_if.write), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_write", 32'(bus_if.write), 32'd0);
        chk("mid_rst_ready", 32'(bus_if.tri_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        push_tri(rnd_tri());
        drain();

        // Random commands, idle gaps and waitrequest.
        wr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            push_tri(rnd_tri());
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end
        drain();
        wr_mode = 0;
        @(posedge clk); #1;

`ifdef TRI_CMD_STATS_EN
        @(negedge clk);
        chk("tri_count", 32'(tri_count), 32'(16'(tri_model)));
        chk("stall_count", stall_count, 32'(stall_model));
`endif
        chk("end_ready", 32'(bus_if.tri_ready), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
